// File: rtl/instr_encoder_pkg.sv
// Shared opcode/op constants, FSM state encoding and the HALT word for the
// instruction encoder and program loader.
package instr_encoder_pkg;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  localparam logic [15:0] HALT_WORD = 16'hE000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Host-side bundle handshake plus instruction-RAM write port of the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [2:0]        rn;
  logic [2:0]        rd;
  logic [2:0]        rm;
  logic [1:0]        shift;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic              mem_write;
  logic              err;
  logic              done;
  logic [ADDR_W:0]   count;

  modport master (
    output start, base_addr, in_valid, opcode, op, rn, rd, rm, shift, imm,
    input  in_ready, mem_addr, mem_din, mem_write, err, done, count
  );

  modport slave (
    input  start, base_addr, in_valid, opcode, op, rn, rd, rm, shift, imm,
    output in_ready, mem_addr, mem_din, mem_write, err, done, count
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: decoded fields and immediate to a 16-bit instruction
// word plus a legality flag (unknown opcode/op pair or out-of-range immediate).
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  opcode_i,
  input  logic [1:0]  op_i,
  input  logic [2:0]  rn_i,
  input  logic [2:0]  rd_i,
  input  logic [2:0]  rm_i,
  input  logic [1:0]  shift_i,
  input  logic [15:0] imm_i,
  output logic [15:0] word_o,
  output logic        legal_o
);

  // An immediate fits when truncation followed by sign extension is lossless.
  function automatic logic fits_imm8(input logic signed [15:0] v);
    return v[15:8] == {8{v[7]}};
  endfunction

  function automatic logic fits_imm5(input logic signed [15:0] v);
    return v[15:5] == {11{v[4]}};
  endfunction

  always_comb begin
    word_o  = '0;
    legal_o = 1'b0;
    case ({opcode_i, op_i})
      {OPC_MOV, OP_MOV_IMM}: begin
        word_o  = {OPC_MOV, OP_MOV_IMM, rn_i, imm_i[7:0]};
        legal_o = fits_imm8(imm_i);
      end
      {OPC_MOV, OP_MOV_REG}: begin
        word_o  = {OPC_MOV, OP_MOV_REG, 3'b000, rd_i, shift_i, rm_i};
        legal_o = 1'b1;
      end
      {OPC_ALU, OP_ADD}, {OPC_ALU, OP_AND}: begin
        word_o  = {OPC_ALU, op_i, rn_i, rd_i, shift_i, rm_i};
        legal_o = 1'b1;
      end
      {OPC_ALU, OP_CMP}: begin
        word_o  = {OPC_ALU, OP_CMP, rn_i, 3'b000, shift_i, rm_i};
        legal_o = 1'b1;
      end
      {OPC_ALU, OP_MVN}: begin
        word_o  = {OPC_ALU, OP_MVN, 3'b000, rd_i, shift_i, rm_i};
        legal_o = 1'b1;
      end
      {OPC_LDR, 2'b00}, {OPC_STR, 2'b00}: begin
        word_o  = {opcode_i, 2'b00, rn_i, rd_i, imm_i[4:0]};
        legal_o = fits_imm5(imm_i);
      end
      {OPC_HALT, 2'b00}: begin
        word_o  = HALT_WORD;
        legal_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts field bundles, packs them and writes each legal word
// to consecutive instruction-RAM addresses until HALT or the last address.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input logic             clk,
  input logic             reset,
  instr_encoder_if.slave  bus
);

  state_t            state_q;
  logic              in_ready_q;
  logic              mem_write_q;
  logic              err_q;
  logic              done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [15:0]       mem_din_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic [15:0]       word;
  logic              legal;
  logic              accept;
  logic              last_word;

  instr_pack u_pack (
    .opcode_i (bus.opcode),
    .op_i     (bus.op),
    .rn_i     (bus.rn),
    .rd_i     (bus.rd),
    .rm_i     (bus.rm),
    .shift_i  (bus.shift),
    .imm_i    (bus.imm),
    .word_o   (word),
    .legal_o  (legal)
  );

  assign mem_addr_d = mem_addr_q + ADDR_W'(1);
  assign count_d    = count_q + (ADDR_W+1)'(1);
  assign accept     = (state_q == ST_RUN) && in_ready_q && bus.in_valid;
  // The top address ends the session rather than wrapping onto earlier code.
  assign last_word  = (mem_din_q == HALT_WORD) || (mem_addr_q == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      mem_write_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      count_q     <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q    <= ST_RUN;
            in_ready_q <= 1'b1;
            mem_addr_q <= bus.base_addr;
            count_q    <= '0;
            done_q     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (legal) begin
              mem_din_q   <= word;
              mem_write_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= ST_WRITE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          mem_write_q <= 1'b0;
          count_q     <= count_d;
          if (last_word) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            mem_addr_q <= mem_addr_d;
            in_ready_q <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_write = mem_write_q;
  assign bus.err       = err_q;
  assign bus.done      = done_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded words, illegal bundles,
// HALT/top-of-memory termination, restart and asynchronous reset mid-write.
module tb_instr_encoder;
  localparam int ADDR_W = 8;

  typedef struct packed {
    logic [2:0]  opc;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [15:0] imm;
  } fld_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   acc;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic fld_t fld(input logic [2:0] opc, input logic [1:0] op,
                               input logic [2:0] rn, input logic [2:0] rd,
                               input logic [2:0] rm, input logic [1:0] sh,
                               input logic [15:0] imm);
    return '{opc, op, rn, rd, rm, sh, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input fld_t f);
    bus.opcode = f.opc;
    bus.op     = f.op;
    bus.rn     = f.rn;
    bus.rd     = f.rd;
    bus.rm     = f.rm;
    bus.shift  = f.sh;
    bus.imm    = f.imm;
  endtask

  task automatic send(input fld_t f, input int maxw, output bit ok);
    drive(f);
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < maxw; i++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] base);
    bus.base_addr = base;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start/in_ready", bus.in_ready, 1);
    chk("start/mem_addr", bus.mem_addr, base);
    chk("start/count", bus.count, 0);
    chk("start/done", bus.done, 0);
  endtask

  task automatic put_word(input string tag, input fld_t f, input logic [7:0] a,
                          input logic [15:0] w, input int cnt, input bit fin);
    logic [7:0] nxt;
    bit ok;
    nxt = fin ? a : a + 8'd1;
    send(f, 4, ok);
    chk({tag, "/accepted"}, ok, 1);
    chk({tag, "/mem_write"}, bus.mem_write, 1);
    chk({tag, "/mem_addr"}, bus.mem_addr, a);
    chk({tag, "/mem_din"}, bus.mem_din, w);
    chk({tag, "/in_ready_low"}, bus.in_ready, 0);
    chk({tag, "/err"}, bus.err, 0);
    step();
    chk({tag, "/count"}, bus.count, cnt);
    chk({tag, "/write_done"}, bus.mem_write, 0);
    chk({tag, "/done"}, bus.done, fin);
    chk({tag, "/in_ready_next"}, bus.in_ready, !fin);
    chk({tag, "/next_addr"}, bus.mem_addr, nxt);
  endtask

  task automatic put_bad(input string tag, input fld_t f, input logic [7:0] a, input int cnt);
    bit ok;
    send(f, 4, ok);
    chk({tag, "/accepted"}, ok, 1);
    chk({tag, "/err"}, bus.err, 1);
    chk({tag, "/no_write"}, bus.mem_write, 0);
    chk({tag, "/in_ready"}, bus.in_ready, 1);
    chk({tag, "/mem_addr"}, bus.mem_addr, a);
    step();
    chk({tag, "/err_clear"}, bus.err, 0);
    chk({tag, "/count"}, bus.count, cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.in_valid  = 1'b0;
    drive('0);
    step();
    step();
    chk("rst/in_ready", bus.in_ready, 0);
    chk("rst/mem_addr", bus.mem_addr, 0);
    chk("rst/mem_din", bus.mem_din, 0);
    chk("rst/mem_write", bus.mem_write, 0);
    chk("rst/err", bus.err, 0);
    chk("rst/done", bus.done, 0);
    chk("rst/count", bus.count, 0);
    reset = 1'b0;
    step();
    chk("idle/in_ready", bus.in_ready, 0);

    // Session 1: back-to-back words, illegal bundles, then HALT.
    do_start(8'h10);
    put_word("mov7",  fld(3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0007), 8'h10, 16'hD007, 1, 1'b0);
    put_word("add",   fld(3'b101, 2'b00, 3'd1, 3'd2, 3'd0, 2'b01, 16'h0000), 8'h11, 16'hA148, 2, 1'b0);
    put_word("movm1", fld(3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'b00, 16'hFFFF), 8'h12, 16'hD1FF, 3, 1'b0);
    put_bad("movC8",  fld(3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'b00, 16'h00C8), 8'h13, 3);
    put_bad("opc0",   fld(3'b000, 2'b00, 3'd1, 3'd2, 3'd3, 2'b00, 16'h0000), 8'h13, 3);
    put_word("halt",  fld(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0000), 8'h13, 16'hE000, 4, 1'b1);

    drive(fld(3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0001));
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("done/ignore_valid", bus.mem_write, 0);
    end
    bus.in_valid = 1'b0;
    chk("done/count_hold", bus.count, 4);
    chk("done/level", bus.done, 1);

    // Session 2: restart from DONE and cover remaining encodings.
    do_start(8'h40);
    put_word("ldr",    fld(3'b011, 2'b00, 3'd2, 3'd3, 3'd0, 2'b00, 16'hFFFF), 8'h40, 16'h627F, 1, 1'b0);
    put_word("str",    fld(3'b100, 2'b00, 3'd5, 3'd1, 3'd0, 2'b00, 16'h000F), 8'h41, 16'h852F, 2, 1'b0);
    put_word("cmp",    fld(3'b101, 2'b01, 3'd3, 3'd7, 3'd4, 2'b10, 16'h0000), 8'h42, 16'hAB14, 3, 1'b0);
    put_word("mvn",    fld(3'b101, 2'b11, 3'd7, 3'd5, 3'd6, 2'b11, 16'h0000), 8'h43, 16'hB8BE, 4, 1'b0);
    put_word("movreg", fld(3'b110, 2'b00, 3'd4, 3'd6, 3'd2, 2'b00, 16'h0000), 8'h44, 16'hC0C2, 5, 1'b0);
    put_word("and",    fld(3'b101, 2'b10, 3'd6, 3'd1, 3'd7, 2'b00, 16'h0000), 8'h45, 16'hB627, 6, 1'b0);
    put_word("movneg", fld(3'b110, 2'b10, 3'd7, 3'd0, 3'd0, 2'b00, 16'hFF80), 8'h46, 16'hD780, 7, 1'b0);
    put_bad("ldr_imm", fld(3'b011, 2'b00, 3'd1, 3'd1, 3'd0, 2'b00, 16'h0010), 8'h47, 7);
    put_bad("halt_op", fld(3'b111, 2'b01, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0000), 8'h47, 7);

    bus.base_addr = 8'h80;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    chk("run_start/mem_addr", bus.mem_addr, 8'h47);
    chk("run_start/count", bus.count, 7);
    chk("run_start/in_ready", bus.in_ready, 1);

    // Asynchronous reset in the middle of a WRITE cycle.
    send(fld(3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0007), 4, acc);
    chk("rstw/accepted", acc, 1);
    chk("rstw/mem_write_pre", bus.mem_write, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstw/mem_write", bus.mem_write, 0);
    chk("rstw/count", bus.count, 0);
    chk("rstw/done", bus.done, 0);
    chk("rstw/in_ready", bus.in_ready, 0);
    chk("rstw/mem_addr", bus.mem_addr, 0);
    chk("rstw/mem_din", bus.mem_din, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rstw/idle", bus.in_ready, 0);

    // Session 3: top of memory ends the session without wrapping.
    do_start(8'hFE);
    put_word("top_fe", fld(3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0007), 8'hFE, 16'hD007, 1, 1'b0);
    put_word("top_ff", fld(3'b110, 2'b10, 3'd2, 3'd0, 3'd0, 2'b00, 16'h0005), 8'hFF, 16'hD205, 2, 1'b1);
    send(fld(3'b110, 2'b10, 3'd3, 3'd0, 3'd0, 2'b00, 16'h0001), 5, acc);
    chk("top_third/accepted", acc, 0);
    chk("top_third/mem_write", bus.mem_write, 0);
    chk("top_third/count", bus.count, 2);
    chk("top_third/done", bus.done, 1);
    chk("top_third/mem_addr", bus.mem_addr, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program loader for the 16-bit datapath CPU. It accepts decoded instruction fields over a valid/ready handshake and packs them into the 16-bit instruction word format the CPU's instruction decoder consumes. Each legal word is written sequentially into instruction memory starting at a programmable base address. It sits between the testbench/host loader and the instruction RAM write port, and is used to build programs before the CPU is released from reset.

## Interface
Parameters:
- ADDR_W, 8, memory address width; memory depth is 2**ADDR_W words.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a load session at base_addr; honoured only in IDLE or DONE.
- base_addr  input  ADDR_W  first write address, sampled on start.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- opcode  input  3  instruction class.
- op  input  2  sub-operation.
- rn, rd, rm  input  3 each  register numbers.
- shift  input  2  shift code.
- imm  input  16  signed immediate, two's complement.
- mem_addr  output  ADDR_W  write address.
- mem_din  output  16  encoded word.
- mem_write  output  1  write strobe, one cycle per word.
- err  output  1  one-cycle pulse: accepted bundle was illegal; nothing written.
- done  output  1  level: session finished.
- count  output  ADDR_W+1  words written this session.

## Operation
- Legal encodings (fields MSB→LSB):
  - 110/10 MOV imm: {110,10,rn,imm[7:0]}.
  - 110/00 MOV reg: {110,00,000,rd,shift,rm}.
  - 101/00 ADD and 101/10 AND: {101,op,rn,rd,shift,rm}.
  - 101/01 CMP: {101,01,rn,000,shift,rm}.
  - 101/11 MVN: {101,11,000,rd,shift,rm}.
  - 011/00 LDR and 100/00 STR: {opc,00,rn,rd,imm[4:0]}.
  - 111/00 HALT: 0xE000.
- Any other opcode/op pair is illegal.
- Immediate range check, the inverse of sign extension:
  - imm8 forms are legal only if imm[15:8] equals 8 copies of imm[7].
  - imm5 forms are legal only if imm[15:5] equals 11 copies of imm[4].
  - Failing the check is illegal.
- Unused fields are ignored, not checked.
- States:
  - IDLE: in_ready=0. On start, load mem_addr=base_addr, clear count and done, and go to RUN.
  - RUN: in_ready=1. On in_valid&in_ready:
    - illegal bundle: err pulses for the next cycle, state stays RUN, address unchanged.
    - legal bundle: register the word into mem_din and go to WRITE.
  - WRITE: mem_write=1, in_ready=0. At the end of the cycle, count+1.
    - If the word is HALT or mem_addr == all-ones, go to DONE; mem_addr holds.
    - Otherwise mem_addr+1 and return to RUN.
  - DONE: done=1, in_ready=0. start restarts the session, same as from IDLE.
- start in RUN or WRITE is ignored. in_valid outside RUN is ignored.
- mem_addr never wraps; the last address ends the session.

## Timing
- All outputs are registered.
- Reset values: state IDLE, in_ready 0, mem_addr 0, mem_din 0, mem_write 0, err 0, done 0, count 0.
- Handshake at edge k: mem_write is high in cycle k+1 with mem_addr/mem_din stable. in_ready returns high in cycle k+2.
- Throughput: one word per 2 cycles.
- Illegal bundle at edge k: err is high in cycle k+1 only, in_ready stays high, no write occurs.
- start at edge k: in_ready is high from cycle k+1.
- reset asserted mid-WRITE clears mem_write immediately (asynchronously). No partial session state survives reset.

## Structure
- Shared package/header holds:
  - opcode constants: MOV=110, ALU=101, LDR=011, STR=100, HALT=111.
  - op constants: ADD, CMP, AND, MVN.
  - state encodings.
  - HALT_WORD=16'hE000.
- One combinational sub-module, instr_pack: fields+imm → {word[15:0], legal}. The top holds the FSM, address counter and output registers.

## Test plan
- start, base 0x10; MOV rn=0, imm=0x0007 → mem_write at 0x10, mem_din=0xD007; count=1.
- ADD rn=1, rd=2, shift=01, rm=0 → 0xA148. MOV rn=1, imm=0xFFFF → 0xD1FF. LDR rn=2, rd=3, imm=0xFFFF → 0x627F. Issue these back-to-back at consecutive addresses; in_ready low every second cycle.
- MOV rn=1, imm=0x00C8 → err one cycle, no mem_write, mem_addr unchanged. Opcode 000 gives the same result.
- HALT after 3 words → write 0xE000, then done=1, count=4, in_ready=0. A later in_valid is ignored.
- base 0xFE, three MOVs → writes at 0xFE and 0xFF, then done, count=2; the third bundle is never accepted.
- reset asserted during WRITE → mem_write, done and count drop to 0 in the same cycle; state is IDLE.
